gpio_in_filter: RTL and testbench



---
 rtl/gpio_in_filter_if.sv | 27 ++
 rtl/gpio_in_filter.sv | 88 ++++++++
 tb/tb_gpio_in_filter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_in_filter_if.sv
// Pad-input filter bus: quasi-static configuration, raw pads and filtered results.
interface gpio_in_filter_if #(
  parameter int unsigned NBITS = 8,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned PRE_W = 16
);
  logic [PRE_W-1:0] cfg_presc;
  logic [CNT_W-1:0] cfg_limit;
  logic [NBITS-1:0] cfg_bypass;
  logic [NBITS-1:0] pad_in;
  logic [NBITS-1:0] din_out;
  logic [NBITS-1:0] rise_o;
  logic [NBITS-1:0] fall_o;
  logic             chg_o;

  // Register block / pad ring side
  modport master (
    output cfg_presc, cfg_limit, cfg_bypass, pad_in,
    input  din_out, rise_o, fall_o, chg_o
  );

  // Filter side
  modport slave (
    input  cfg_presc, cfg_limit, cfg_bypass, pad_in,
    output din_out, rise_o, fall_o, chg_o
  );
endinterface

// File: rtl/gpio_in_filter.sv
// GPIO input conditioning: 2-flop synchroniser, prescaled debounce filter and
// per-bit rise/fall pulse generation feeding the GPIO core and interrupt logic.
module gpio_in_filter #(
  parameter int unsigned NBITS = 8,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned PRE_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  gpio_in_filter_if.slave  bus
);

  logic [NBITS-1:0]            s1;
  logic [NBITS-1:0]            s2;
  logic [PRE_W-1:0]            pre;
  logic [PRE_W-1:0]            pre_next;
  logic                        tick_c;
  logic [NBITS-1:0]            st;
  logic [NBITS-1:0]            st_next;
  logic [NBITS-1:0][CNT_W-1:0] c;
  logic [NBITS-1:0][CNT_W-1:0] c_next;
  logic [NBITS-1:0]            rise_q;
  logic [NBITS-1:0]            fall_q;
  logic                        chg_q;

  // Synchroniser: plain flop pair, nothing between the stages
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.pad_in;
      s2 <= s1;
    end
  end

  // Sample tick; an over-range count (prescale lowered) is treated as a match
  always_comb begin
    tick_c   = (pre >= bus.cfg_presc);
    pre_next = tick_c ? '0 : pre + PRE_W'(1);
  end

  // Per-bit debounce: accept a change after cfg_limit+1 consecutive mismatching ticks
  always_comb begin
    st_next = st;
    c_next  = c;
    for (int unsigned i = 0; i < NBITS; i++) begin
      if (bus.cfg_bypass[i]) begin
        st_next[i] = s2[i];
        c_next[i]  = '0;
      end else if (tick_c) begin
        if (s2[i] == st[i]) begin
          c_next[i] = '0;
        end else if (c[i] >= bus.cfg_limit) begin
          st_next[i] = s2[i];
          c_next[i]  = '0;
        end else begin
          c_next[i] = c[i] + CNT_W'(1);
        end
      end
    end
  end

  // Filter state, prescaler and edge pulses aligned with the new filtered level
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pre    <= '0;
      st     <= '0;
      c      <= '0;
      rise_q <= '0;
      fall_q <= '0;
      chg_q  <= 1'b0;
    end else begin
      pre    <= pre_next;
      st     <= st_next;
      c      <= c_next;
      rise_q <= st_next & ~st;
      fall_q <= ~st_next & st;
      chg_q  <= |(st_next ^ st);
    end
  end

  assign bus.din_out = st;
  assign bus.rise_o  = rise_q;
  assign bus.fall_o  = fall_q;
  assign bus.chg_o   = chg_q;

endmodule

// File: tb/tb_gpio_in_filter.sv
// Randomised and directed check of gpio_in_filter against a cycle-level behavioural model.
module tb_gpio_in_filter;

  localparam int unsigned NB = 8;
  localparam int unsigned CW = 8;
  localparam int unsigned PW = 16;

  logic clk;
  logic rstn;

  gpio_in_filter_if #(.NBITS(NB), .CNT_W(CW), .PRE_W(PW)) bus ();

  gpio_in_filter #(.NBITS(NB), .CNT_W(CW), .PRE_W(PW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: pad samples delayed two clocks, a tick every (presc+1)
  // cycles, and a per-bit streak of disagreeing ticks that flips the level.
  logic [NB-1:0] m_p1, m_p2, m_din, m_rise, m_fall;
  logic          m_chg;
  int            m_pre;
  int            m_streak [NB];

  always @(posedge clk or negedge rstn) begin : model
    logic [NB-1:0] nd;
    logic          tk;
    if (!rstn) begin
      m_p1 = '0; m_p2 = '0; m_din = '0; m_rise = '0; m_fall = '0; m_chg = 1'b0;
      m_pre = 0;
      for (int i = 0; i < int'(NB); i++) m_streak[i] = 0;
    end else begin
      tk = (m_pre >= int'(bus.cfg_presc));
      m_pre = tk ? 0 : m_pre + 1;
      nd = m_din;
      for (int i = 0; i < int'(NB); i++) begin
        if (bus.cfg_bypass[i]) begin
          nd[i] = m_p2[i];
          m_streak[i] = 0;
        end else if (tk) begin
          if (m_p2[i] == m_din[i]) m_streak[i] = 0;
          else begin
            m_streak[i] = m_streak[i] + 1;
            if (m_streak[i] > int'(bus.cfg_limit)) begin
              nd[i] = m_p2[i];
              m_streak[i] = 0;
            end
          end
        end
      end
      m_rise = nd & ~m_din;
      m_fall = m_din & ~nd;
      m_chg  = (nd != m_din);
      m_din  = nd;
      m_p2   = m_p1;
      m_p1   = bus.pad_in;
    end
  end

  // Per-cycle comparison of every output against the model
  always @(posedge clk) begin
    #1;
    chk("din_out", bus.din_out, m_din);
    chk("rise_o",  bus.rise_o,  m_rise);
    chk("fall_o",  bus.fall_o,  m_fall);
    chk("chg_o",   bus.chg_o,   m_chg);
    chk("rise_fall_excl", bus.rise_o & bus.fall_o, '0);
  end

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  logic [NB-1:0] acc;
  int            cnt;
  logic          found;

  initial begin
    rstn = 1'b0;
    bus.cfg_presc  = '0;
    bus.cfg_limit  = 8'd3;
    bus.cfg_bypass = '0;
    bus.pad_in     = '0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    after_edge();
    chk("reset_din", bus.din_out, 8'h00);
    chk("reset_chg", bus.chg_o, 1'b0);

    // Debounced rise, limit 3: visible at edge 5 after capture
    @(negedge clk);
    bus.pad_in = 8'h01;
    repeat (5) @(posedge clk);
    #1;
    chk("t1_din_edge4", bus.din_out, 8'h00);
    after_edge();
    chk("t1_din_edge5", bus.din_out, 8'h01);
    chk("t1_rise", bus.rise_o, 8'h01);
    chk("t1_chg", bus.chg_o, 1'b1);
    chk("t1_model_pin", m_din, 8'h01);
    after_edge();
    chk("t1_rise_gone", bus.rise_o, 8'h00);

    // Three-cycle glitch is rejected
    @(negedge clk);
    bus.pad_in = 8'h00;
    repeat (12) @(negedge clk);
    bus.pad_in = 8'h01;
    acc = '0;
    repeat (3) begin
      after_edge();
      acc |= bus.din_out | bus.rise_o | bus.fall_o;
    end
    @(negedge clk);
    bus.pad_in = 8'h00;
    repeat (12) begin
      after_edge();
      acc |= bus.din_out | bus.rise_o | bus.fall_o;
    end
    chk("t2_glitch_quiet", acc, 8'h00);

    // Bypass: level follows the synchroniser at edge 2
    @(negedge clk);
    bus.cfg_bypass = 8'hFF;
    bus.pad_in     = 8'hA5;
    after_edge();
    after_edge();
    chk("t3_din_edge1", bus.din_out, 8'h00);
    after_edge();
    chk("t3_din_edge2", bus.din_out, 8'hA5);
    chk("t3_rise", bus.rise_o, 8'hA5);
    @(negedge clk);
    bus.pad_in = 8'h5A;
    repeat (3) after_edge();
    chk("t3_fall2", bus.fall_o, 8'hA5);
    chk("t3_rise2", bus.rise_o, 8'h5A);
    chk("t3_model_pin", m_din, 8'h5A);

    // Prescaled debounce: one rise on bit 7
    @(negedge clk);
    bus.cfg_bypass = 8'h00;
    bus.cfg_presc  = 16'd4;
    bus.cfg_limit  = 8'd1;
    bus.pad_in     = 8'hDA;
    cnt = 0;
    repeat (30) begin
      after_edge();
      if (bus.rise_o[7]) cnt++;
    end
    chk("t4_rise7_count", 32'(cnt), 32'd1);
    chk("t4_din7", bus.din_out[7], 1'b1);

    // Lowering the limit mid-count accepts at the next tick
    @(negedge clk);
    bus.cfg_limit = 8'd10;
    bus.pad_in    = 8'h5A;
    repeat (33) after_edge();
    chk("t5_still_high", bus.din_out[7], 1'b1);
    @(negedge clk);
    bus.cfg_limit = 8'd2;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      after_edge();
      if (!bus.din_out[7]) begin
        found = 1'b1;
        break;
      end
    end
    chk("t5_accept_after_lower", found, 1'b1);

    // Asynchronous reset mid-count, then rise on release
    @(negedge clk);
    bus.cfg_presc  = '0;
    bus.cfg_bypass = 8'hFF;
    bus.pad_in     = 8'hFF;
    repeat (4) after_edge();
    chk("t6_din_ff", bus.din_out, 8'hFF);
    @(negedge clk);
    bus.cfg_bypass = 8'h00;
    bus.cfg_limit  = 8'd5;
    bus.pad_in     = 8'h00;
    repeat (3) @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    chk("t6_async_din", bus.din_out, 8'h00);
    chk("t6_async_rise", bus.rise_o, 8'h00);
    chk("t6_async_fall", bus.fall_o, 8'h00);
    chk("t6_async_chg", bus.chg_o, 1'b0);
    bus.pad_in    = 8'hFF;
    bus.cfg_limit = 8'd0;
    @(negedge clk);
    rstn = 1'b1;
    after_edge();
    after_edge();
    chk("t6_din_edge1", bus.din_out, 8'h00);
    after_edge();
    chk("t6_rise_edge2", bus.rise_o, 8'hFF);
    chk("t6_chg_edge2", bus.chg_o, 1'b1);
    after_edge();
    chk("t6_rise_once", bus.rise_o, 8'h00);

    // Randomised traffic: bouncing pads, changing config, occasional resets
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (!rstn) rstn = 1'b1;
      else if ($urandom_range(0, 599) == 0) rstn = 1'b0;
      if ((cyc % 150) == 0) begin
        bus.cfg_presc = PW'($urandom_range(0, 3));
        bus.cfg_limit = CW'($urandom_range(0, 4));
      end
      if ((cyc % 400) == 0) bus.cfg_bypass = NB'($urandom & $urandom);
      for (int b = 0; b < int'(NB); b++)
        if ($urandom_range(0, 15) == 0) bus.pad_in[b] = ~bus.pad_in[b];
    end
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
